// File: rtl/gray_seq_pkg.sv
// gray_seq_pkg -- shared state encoding, divider width and Gray helper for gray_seq_ctrl (rev 1.0)
`default_nettype none

package gray_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DIV_W      = 8;
  localparam int GRAY_MAX_W = 64;

  // Callers zero-extend into and truncate out of the wide form, which keeps
  // the MSB of the narrow code equal to the MSB of its binary input.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_encoder.sv
// gray_encoder -- purely combinational binary-to-Gray conversion at any WIDTH (rev 1.0)
`default_nettype none

module gray_encoder
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = WIDTH'(bin2gray(GRAY_MAX_W'(bin)));

endmodule

`default_nettype wire

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl -- paced Gray-code word sequencer on a valid/ready stream (rev 1.0)
// Optional down-counting and the dir port are enabled with GRAY_SEQ_DOWN_EN.
`default_nettype none

module gray_seq_ctrl
  import gray_seq_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef GRAY_SEQ_DOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] out_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             wrap
);

  // GAP lasts STEP_DIV-1 cycles; the divider exits on its last count value.
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'((STEP_DIV > 1) ? (STEP_DIV - 2) : 0);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic             stop_pend, stop_pend_nxt;
  logic             wrap_nxt;
  logic             hs;

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    div_nxt       = div;
    stop_pend_nxt = stop_pend;
    wrap_nxt      = 1'b0;
    hs            = (state == EMIT) && out_ready;

    case (state)
      IDLE: begin
        if (load) count_nxt = load_val;
        if (start) state_nxt = EMIT;
      end
      EMIT: begin
        if (hs) begin
`ifdef GRAY_SEQ_DOWN_EN
          if (dir) begin
            count_nxt = count - ONE;
            wrap_nxt  = (count == '0);
          end else begin
            count_nxt = count + ONE;
            wrap_nxt  = &count;
          end
`else
          count_nxt = count + ONE;
          wrap_nxt  = &count;
`endif
          div_nxt = '0;
          if (stop || stop_pend) state_nxt = IDLE;
          else if (STEP_DIV > 1) state_nxt = GAP;
          else                   state_nxt = EMIT;
        end else if (stop) begin
          stop_pend_nxt = 1'b1;
        end
      end
      GAP: begin
        if (stop) begin
          state_nxt = IDLE;
          div_nxt   = '0;
        end else if (div == GAP_LAST) begin
          state_nxt = EMIT;
          div_nxt   = '0;
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == IDLE) stop_pend_nxt = 1'b0;
  end

  gray_encoder #(
    .WIDTH(WIDTH)
  ) u_gray_encoder (
    .bin (count_nxt),
    .gray(gray_nxt)
  );

  // Outputs are registered from next-state values so they carry no input path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      div       <= '0;
      stop_pend <= 1'b0;
      out_gray  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      div       <= div_nxt;
      stop_pend <= stop_pend_nxt;
      out_gray  <= gray_nxt;
      out_valid <= (state_nxt == EMIT);
      busy      <= (state_nxt != IDLE);
      wrap      <= wrap_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl -- directed self-checking bench for gray_seq_ctrl (STEP_DIV=1 and STEP_DIV=4 instances)
`default_nettype none

module tb_gray_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, load, out_ready;
  logic [3:0] load_val;
  logic       dir;
  logic [3:0] out_gray;
  logic       out_valid, busy, wrap;

  logic       start4, stop4, load4, ready4;
  logic [3:0] gray4;
  logic       valid4, busy4, wrap4;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_seq_ctrl #(.WIDTH(4), .STEP_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load(load),
    .load_val(load_val),
`ifdef GRAY_SEQ_DOWN_EN
    .dir(dir),
`endif
    .out_gray(out_gray), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .wrap(wrap)
  );

  gray_seq_ctrl #(.WIDTH(4), .STEP_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop4), .load(load4),
    .load_val(load_val),
`ifdef GRAY_SEQ_DOWN_EN
    .dir(dir),
`endif
    .out_gray(gray4), .out_valid(valid4), .out_ready(ready4),
    .busy(busy4), .wrap(wrap4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [3:0] gtab [16];

  initial begin
    gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    rst_n = 1'b0; start = 0; stop = 0; load = 0; load_val = 4'h0; dir = 0;
    out_ready = 1'b1; start4 = 0; stop4 = 0; load4 = 0; ready4 = 1'b1;
    tick(2);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_gray",  32'(out_gray),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_wrap",  32'(wrap),      32'd0);
    rst_n = 1'b1;
    tick(1);

    // Full up-count sequence, back-to-back
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("seq_gray%0d", i), 32'(out_gray), 32'(gtab[i]));
      check($sformatf("seq_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("seq_wrap%0d", i), 32'(wrap), 32'd0);
      tick(1);
    end
    check("wrap_pulse", 32'(wrap), 32'd1);
    check("wrap_gray",  32'(out_gray), 32'h0);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("stop_valid", 32'(out_valid), 32'd0);
    check("stop_busy",  32'(busy),      32'd0);
    check("stop_gray",  32'(out_gray),  32'h1);
    check("wrap_clear", 32'(wrap),      32'd0);

    // Load and start together, then backpressure
    load_val = 4'd5; load = 1'b1; start = 1'b1;
    tick(1);
    load = 1'b0; start = 1'b0; out_ready = 1'b0;
    check("load_gray", 32'(out_gray), 32'h7);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check($sformatf("bp_gray%0d", i), 32'(out_gray), 32'h7);
      check($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick(1);
    check("bp_adv", 32'(out_gray), 32'h5);

    // Stop while stalled; start and load while busy are ignored
    out_ready = 1'b0; stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_gray",  32'(out_gray),  32'h5);
    start = 1'b1; load = 1'b1; load_val = 4'd0;
    tick(1);
    start = 1'b0; load = 1'b0;
    check("busy_ign_gray", 32'(out_gray), 32'h5);
    check("busy_ign_busy", 32'(busy),     32'd1);
    out_ready = 1'b1;
    tick(1);
    check("pend_valid", 32'(out_valid), 32'd0);
    check("pend_busy",  32'(busy),      32'd0);
    check("pend_gray",  32'(out_gray),  32'h4);
    tick(1);
    check("pend_idle", 32'(out_valid), 32'd0);

    // Paced instance: one word per 4 cycles, stop during GAP
    start4 = 1'b1;
    tick(1);
    start4 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("div_valid%0d", i), 32'(valid4), (i % 4 == 0) ? 32'd1 : 32'd0);
      if (i == 4) check("div_gray", 32'(gray4), 32'h1);
      if (i < 5) tick(1);
    end
    check("div_gap_busy", 32'(busy4), 32'd1);
    stop4 = 1'b1;
    tick(1);
    stop4 = 1'b0;
    check("div_stop_busy", 32'(busy4), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check($sformatf("div_noword%0d", i), 32'(valid4), 32'd0);
    end
    check("div_stop_gray", 32'(gray4), 32'h3);

    // Reset mid-run
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_gray",  32'(out_gray),  32'd0);
    tick(1);
    check("mrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(1);

`ifdef GRAY_SEQ_DOWN_EN
    load_val = 4'd0; load = 1'b1; start = 1'b1; dir = 1'b1;
    tick(1);
    load = 1'b0; start = 1'b0;
    check("down_first", 32'(out_gray), 32'h0);
    tick(1);
    check("down_gray15", 32'(out_gray), 32'h8);
    check("down_wrap",   32'(wrap),     32'd1);
    tick(1);
    check("down_gray14", 32'(out_gray), 32'h9);
    check("down_wrap0",  32'(wrap),     32'd0);
    dir = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gray_seq_ctrl.md
# gray_seq_ctrl

Sequencer for the binary-to-Gray datapath. It holds a binary step counter, feeds it through a combinational Gray encoder, and presents each Gray code word on a registered valid/ready output stream. Software or a parent FSM controls it with start, stop and load pulses. It is the block that drives Gray-coded position and test patterns into downstream logic at a controlled rate.

## Interface
- WIDTH, 4: counter and code width in bits; minimum 2.
- STEP_DIV, 1: minimum cycles between consecutive code words; 1 means back-to-back; range 1..255.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins emission from the current count.
- stop  in  1  pulse; ends emission after the current word.
- load  in  1  pulse; loads load_val into the counter. Honoured in IDLE only.
- load_val  in  WIDTH  binary value for load.
- dir  in  1  0 = count up, 1 = count down. Present only with GRAY_SEQ_DOWN_EN.
- out_gray  out  WIDTH  Gray code of the counter; bit i = b[i+1] XOR b[i]; MSB = b[MSB].
- out_valid  out  1  out_gray holds a word.
- out_ready  in  1  downstream accepts the word.
- busy  out  1  high in EMIT or GAP.
- wrap  out  1  one-cycle pulse on the cycle the counter wraps.

## Operation
- States:
  - IDLE: out_valid=0, busy=0.
  - EMIT: out_valid=1.
  - GAP: out_valid=0, divider running.
- IDLE:
  - load → counter = load_val.
  - start → EMIT.
  - start and load in the same cycle: the load is applied first, so the first word is gray(load_val).
- EMIT:
  - out_gray is stable while out_valid && !out_ready. The word never changes or drops until accepted.
  - On handshake (out_valid && out_ready), if stop is pending or asserted this cycle → IDLE. The counter still advances.
  - Otherwise on handshake the counter advances. Next state is GAP if STEP_DIV>1, else EMIT.
- GAP:
  - The divider counts STEP_DIV-1 cycles, then → EMIT.
  - stop in GAP → IDLE on the next edge.
- stop in EMIT without a handshake sets stop_pend. stop_pend clears on entry to IDLE.
- start outside IDLE is ignored. load outside IDLE is ignored.
- Counter arithmetic is modulo 2^WIDTH.
  - Up: 2^WIDTH-1 → 0, with a wrap pulse in the same cycle as the advance.
  - Down: 0 → 2^WIDTH-1, with a wrap pulse.

## Timing
- Reset values:
  - Counter 0, state IDLE.
  - out_gray 0, out_valid 0, busy 0, wrap 0.
  - stop_pend 0, divider 0.
- Reset asserted mid-operation aborts immediately to the reset values. Any word in flight is discarded.
- Latency:
  - start sampled at edge N → out_valid=1 after edge N, with out_gray = gray(counter) registered at edge N.
  - Handshake at edge M with STEP_DIV=1 → the next word is visible after edge M.
  - Handshake at edge M with STEP_DIV=k → the next word is visible after edge M+k-1.
- Throughput: one word per max(STEP_DIV, 1) cycles when out_ready is held high.
- wrap is registered and aligned with the cycle after the wrapping handshake.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- GRAY_SEQ_DOWN_EN defined:
  - The dir port exists.
  - dir is sampled at each handshake and selects increment or decrement.
  - Down-wrap pulses wrap.
- GRAY_SEQ_DOWN_EN undefined:
  - No dir port.
  - The counter only increments. The decrement logic is absent.

## Structure
- Shared package gray_seq_pkg holds:
  - the state enum (IDLE, EMIT, GAP);
  - the divider width constant (8 bits);
  - a bin2gray function usable at any WIDTH.
- One sub-module, gray_encoder: parameterised WIDTH, purely combinational binary-to-Gray conversion. It sits between the counter and the out_gray register.

## Test plan
- Reset, then start with out_ready=1, STEP_DIV=1, WIDTH=4:
  - out_gray sequence is 0000, 0001, 0011, 0010, 0110, …, 1000 on consecutive cycles.
  - wrap pulses after the 1000 word is accepted.
- load_val=5 and start in the same cycle → first word 0111.
- Backpressure: out_ready=0 for 6 cycles while out_valid=1 → out_gray stays constant. It advances one cycle after out_ready rises.
- STEP_DIV=4, out_ready=1 → out_valid high one cycle in every 4. stop asserted during GAP → IDLE with no further word.
- stop during a stalled EMIT → the held word is still delivered on out_ready, then busy=0. start while busy is ignored.
- With GRAY_SEQ_DOWN_EN: load 0, dir=1, start:
  - First word 0000, then 1000 (gray 15), with wrap pulsing.
- Reset asserted mid-run: the next cycle shows out_valid=0 and counter 0.
